// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad-to-BCD entry block.
// Key map is indexed by {row, col}.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_HELD
  } state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_e;

  localparam logic [3:0] KEY_CLR  = 4'hA;
  localparam logic [3:0] KEY_BKSP = 4'hB;

  // Entry 0 (r0c0) is the least significant nibble: r0=1,2,3,A r1=4,5,6,B r2=7,8,9,C r3=E,0,F,D
  localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column-rotating keypad scanner: synchronizes ROW, drives COL and
// classifies each full 4-column frame as NONE, SINGLE(r,c) or MULTI.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       frame_end_o,
  output frame_e     frame_kind_o,
  output logic [1:0] key_row_o,
  output logic [1:0] key_col_o
);

  localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic          acc_one_q, acc_one_d;
  logic          acc_multi_q, acc_multi_d;
  logic [1:0]    acc_row_q, acc_row_d;
  logic [1:0]    acc_col_q, acc_col_d;

  logic          scan_tick;
  logic [3:0]    cur_low;
  logic [2:0]    cur_cnt;
  logic [1:0]    cur_row;
  logic          tot_one, tot_multi;

  always_comb begin
    cur_low = ~row_sync_q;
    cur_cnt = '0;
    cur_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (cur_low[i]) begin
        cur_cnt = cur_cnt + 3'd1;
        cur_row = 2'(i);
      end
    end

    // Frame totals include the column being sampled on this tick
    tot_multi = acc_multi_q || (cur_cnt > 3'd1) || (acc_one_q && (cur_cnt == 3'd1));
    tot_one   = !tot_multi && (acc_one_q || (cur_cnt == 3'd1));

    scan_tick = (div_q == DW'(SCAN_DIV - 1));
    div_d     = scan_tick ? '0 : div_q + DW'(1);
    col_idx_d = scan_tick ? col_idx_q + 2'd1 : col_idx_q;

    acc_one_d   = acc_one_q;
    acc_multi_d = acc_multi_q;
    acc_row_d   = acc_row_q;
    acc_col_d   = acc_col_q;
    if (scan_tick) begin
      if (col_idx_q == 2'd3) begin
        acc_one_d   = 1'b0;
        acc_multi_d = 1'b0;
        acc_row_d   = '0;
        acc_col_d   = '0;
      end else begin
        acc_one_d   = tot_one;
        acc_multi_d = tot_multi;
        if (!acc_one_q && (cur_cnt == 3'd1)) begin
          acc_row_d = cur_row;
          acc_col_d = col_idx_q;
        end
      end
    end

    frame_end_o  = scan_tick && (col_idx_q == 2'd3);
    frame_kind_o = tot_multi ? FR_MULTI : (tot_one ? FR_SINGLE : FR_NONE);
    key_row_o    = acc_one_q ? acc_row_q : cur_row;
    key_col_o    = acc_one_q ? acc_col_q : col_idx_q;

    case (col_idx_q)
      2'd0:    col_o = 4'b1110;
      2'd1:    col_o = 4'b1101;
      2'd2:    col_o = 4'b1011;
      default: col_o = 4'b0111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q  <= '1;
      row_sync_q  <= '1;
      div_q       <= '0;
      col_idx_q   <= '0;
      acc_one_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_row_q   <= '0;
      acc_col_q   <= '0;
    end else begin
      row_meta_q  <= row_i;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      acc_one_q   <= acc_one_d;
      acc_multi_q <= acc_multi_d;
      acc_row_q   <= acc_row_d;
      acc_col_q   <= acc_col_d;
    end
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Debounced 4x4 keypad entry into a 4-digit BCD shift register with
// clear and backspace keys; one KEY_VALID pulse per accepted press.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 25000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [15:0] BCD,
  output logic        KEY_VALID,
  output logic [3:0]  KEY_CODE
);

  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic        frame_end;
  frame_e      frame_kind;
  logic [1:0]  key_row, key_col;
  logic [3:0]  frame_code;

  state_e      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .clk          (clk),
    .reset        (reset),
    .row_i        (ROW),
    .col_o        (COL),
    .frame_end_o  (frame_end),
    .frame_kind_o (frame_kind),
    .key_row_o    (key_row),
    .key_col_o    (key_col)
  );

  assign frame_code = key_lookup(key_row, key_col);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_cnt_d   = rel_cnt_q;
    bcd_d       = bcd_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_end && (frame_kind == FR_SINGLE)) begin
          cand_d  = frame_code;
          cnt_d   = CW'(1);
          state_d = (DEBOUNCE_FRAMES == 1) ? ST_PRESSED : ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (frame_end) begin
          if ((frame_kind == FR_SINGLE) && (frame_code == cand_q)) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(DEBOUNCE_FRAMES)) state_d = ST_PRESSED;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_PRESSED: begin
        cnt_d     = '0;
        rel_cnt_d = '0;
        state_d   = ST_HELD;
      end
      ST_HELD: begin
        if (frame_end) begin
          if (frame_kind == FR_NONE) begin
            rel_cnt_d = rel_cnt_q + CW'(1);
            if (rel_cnt_d == CW'(DEBOUNCE_FRAMES)) begin
              rel_cnt_d = '0;
              state_d   = ST_IDLE;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered on entry to PRESSED so KEY_VALID and the new BCD appear together
    if (state_d == ST_PRESSED) begin
      key_valid_d = 1'b1;
      key_code_d  = cand_d;
      if (cand_d <= 4'd9)            bcd_d = {bcd_q[11:0], cand_d};
      else if (cand_d == KEY_CLR)    bcd_d = '0;
      else if (cand_d == KEY_BKSP)   bcd_d = {4'h0, bcd_q[15:4]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      rel_cnt_q   <= '0;
      bcd_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      bcd_q       <= bcd_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign BCD       = bcd_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_CODE  = key_code_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Scoreboard bench for keypad_bcd_entry with a passive 4x4 keypad model
// (SCAN_DIV=4, DEBOUNCE_FRAMES=2, so one frame is 16 clocks).
module tb_keypad_bcd_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [15:0] BCD;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;

  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] bcd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] colpat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_bcd_entry #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ROW       (ROW),
    .COL       (COL),
    .BCD       (BCD),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; frame-end ticks fall where cyc%16==15
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!COL[c] && pressed[r*4+c]) ROW[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && KEY_VALID) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_key_valid actual code=%0h bcd=%04h required=no pulse (cyc %0d)",
                 KEY_CODE, BCD, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("key_code", {28'd0, KEY_CODE}, {28'd0, mon_e.code});
        check("bcd", {16'd0, BCD}, {16'd0, mon_e.bcd});
        if (mon_e.cyc >= 0) check("valid_cycle", cyc, mon_e.cyc);
        else                check("valid_phase", cyc % 16, 0);
      end
    end
  end

  task automatic expect_key(input logic [3:0] code, input logic [15:0] bcd, input int at);
    exp_t e;
    e.code = code;
    e.bcd  = bcd;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [15:0] k, input int frames);
    int guard = 0;
    while ((cyc % 16 != 0) && (guard < 32)) begin
      @(negedge clk);
      guard++;
    end
    pressed = k;
    repeat (frames * 16) @(negedge clk);
  endtask

  task automatic key(input int idx, input logic [3:0] code, input logic [15:0] bcd);
    expect_key(code, bcd, -1);
    hold(16'h1 << idx, 2);
    hold('0, 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {28'd0, COL}, 32'hE);
    check({tag, "_bcd"}, {16'd0, BCD}, 32'h0);
    check({tag, "_key_valid"}, {31'd0, KEY_VALID}, 32'h0);
    check({tag, "_key_code"}, {28'd0, KEY_CODE}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // r1c1 held 3 frames from reset release: pulse right after the 2nd frame end
    expect_key(4'h5, 16'h0005, 32);
    reset = 1'b0;
    hold(16'h1 << 5, 3);
    hold('0, 2);

    key(3, 4'hA, 16'h0000);
    key(0, 4'h1, 16'h0001);
    key(1, 4'h2, 16'h0012);
    key(2, 4'h3, 16'h0123);
    key(4, 4'h4, 16'h1234);
    key(5, 4'h5, 16'h2345);
    key(7, 4'hB, 16'h0234);
    key(3, 4'hA, 16'h0000);
    key(10, 4'h9, 16'h0009);
    key(11, 4'hC, 16'h0009);

    repeat (5) begin
      hold(16'h1 << 0, 1);
      hold('0, 1);
    end
    hold((16'h1 << 0) | (16'h1 << 5), 4);
    hold('0, 2);

    key(3, 4'hA, 16'h0000);
    expect_key(4'h7, 16'h0007, -1);
    hold(16'h1 << 8, 10);
    hold('0, 1);
    hold(16'h1 << 8, 2);
    hold('0, 2);
    expect_key(4'h7, 16'h0077, -1);
    hold(16'h1 << 8, 2);
    hold('0, 2);
    check("bcd_before_reset", {16'd0, BCD}, 32'h0077);

    // Reset while debouncing key 1; the held key must debounce again from scratch
    hold(16'h1 << 0, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    expect_key(4'h1, 16'h0001, 32);
    for (int k = 0; k < 20; k++) begin
      if (k % 4 == 0) check("col_rotation", {28'd0, COL}, {28'd0, colpat[(k / 4) % 4]});
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    pressed = '0;
    repeat (48) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
